// File: rtl/oram_spld_pkg.sv
// Shared definitions for the scratchpad-load command path: FSM encoding,
// the filter-side opcode and default widths.
package oram_spld_pkg;

    localparam int SIZE_W_DEF = 16;

    localparam logic [14:0] SPLD_OPCODE = 15'b011000000000011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } spld_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spld_cmd_receiver.sv
// Scratchpad-side endpoint of the filter command channel: allocates a region
// in the scratchpad SRAM and zero-fills it one word per accepted write.
module spld_cmd_receiver
    import oram_spld_pkg::*;
#(
    parameter int SP_DEPTH = 4096,
    parameter int SP_AW    = $clog2(SP_DEPTH),
    parameter int SIZE_W   = SIZE_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              IFSPCmdValid,
    output logic              IFSPCmdReady,
    input  logic [SIZE_W-1:0] MemSize,
    input  logic              isMemReplaceable,
    output logic              SpWrEn,
    output logic [SP_AW-1:0]  SpWrAddr,
    output logic [31:0]       SpWrData,
    input  logic              SpWrReady,
    output logic [SP_AW:0]    RegionBase,
    output logic [SIZE_W-1:0] RegionSize,
    output logic              RegionValid,
    output logic              SpOverflow
);

    // End address is compared one bit wider than either operand so the sum never wraps.
    localparam int            EW      = max_int(SP_AW + 1, SIZE_W) + 1;
    localparam logic [EW-1:0] DEPTH_E = EW'(SP_DEPTH);

    spld_state_t       r_state;
    spld_state_t       w_state_nxt;
    logic [SP_AW:0]    r_free_ptr;
    logic [SP_AW:0]    r_wr_ptr;
    logic [SP_AW:0]    r_base;
    logic [SP_AW:0]    r_end;
    logic [SIZE_W-1:0] r_cnt;
    logic [SIZE_W-1:0] r_size;
    logic              r_commit;
    logic              r_ready;
    logic              r_wr_en;
    logic              r_overflow;
    logic [SP_AW:0]    r_region_base;
    logic [SIZE_W-1:0] r_region_size;
    logic              r_region_valid;

    logic              w_accept;
    logic [SP_AW:0]    w_base;
    logic [EW-1:0]     w_end;
    logic              w_zero;
    logic              w_ovf;
    logic              w_wr_fire;
    logic              w_ready_nxt;
    logic              w_wr_en_nxt;
    logic              w_overflow_nxt;

    assign w_accept  = IFSPCmdValid & r_ready;
    assign w_base    = isMemReplaceable ? {(SP_AW + 1){1'b0}} : r_free_ptr;
    assign w_end     = EW'(w_base) + EW'(MemSize);
    assign w_zero    = (MemSize == {SIZE_W{1'b0}});
    assign w_ovf     = (w_end > DEPTH_E);
    assign w_wr_fire = (r_state == ST_FILL) & SpWrReady;

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_zero) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_ovf) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (w_wr_fire && (r_cnt == SIZE_W'(1))) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the next state so that the outputs can be registered
    always_comb begin
        w_ready_nxt    = 1'b0;
        w_wr_en_nxt    = 1'b0;
        w_overflow_nxt = 1'b0;
        case (w_state_nxt)
            ST_IDLE: w_ready_nxt    = 1'b1;
            ST_FILL: w_wr_en_nxt    = 1'b1;
            ST_DONE: w_ready_nxt    = 1'b0;
            ST_ERR:  w_overflow_nxt = 1'b1;
            default: w_ready_nxt    = 1'b0;
        endcase
    end

    // Registered handshake, write-enable and overflow pulse
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_ready    <= 1'b1;
            r_wr_en    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_ready    <= w_ready_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Command latch and inline fill address generator
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= {(SP_AW + 1){1'b0}};
            r_cnt    <= {SIZE_W{1'b0}};
            r_base   <= {(SP_AW + 1){1'b0}};
            r_end    <= {(SP_AW + 1){1'b0}};
            r_size   <= {SIZE_W{1'b0}};
            r_commit <= 1'b0;
        end else if (w_accept) begin
            r_commit <= ~w_zero & ~w_ovf;
            if (!w_zero && !w_ovf) begin
                r_wr_ptr <= w_base;
                r_cnt    <= MemSize;
                r_base   <= w_base;
                r_end    <= w_end[SP_AW:0];
                r_size   <= MemSize;
            end
        end else if (w_wr_fire) begin
            r_wr_ptr <= r_wr_ptr + (SP_AW + 1)'(1);
            r_cnt    <= r_cnt - SIZE_W'(1);
        end
    end

    // Allocation pointer and published region; only a completed fill is recorded
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_free_ptr     <= {(SP_AW + 1){1'b0}};
            r_region_base  <= {(SP_AW + 1){1'b0}};
            r_region_size  <= {SIZE_W{1'b0}};
            r_region_valid <= 1'b0;
        end else if (w_accept && w_zero && isMemReplaceable) begin
            r_free_ptr     <= {(SP_AW + 1){1'b0}};
            r_region_valid <= 1'b0;
        end else if ((r_state == ST_DONE) && r_commit) begin
            r_free_ptr     <= r_end;
            r_region_base  <= r_base;
            r_region_size  <= r_size;
            r_region_valid <= 1'b1;
        end
    end

    assign IFSPCmdReady = r_ready;
    assign SpWrEn       = r_wr_en;
    assign SpWrAddr     = r_wr_ptr[SP_AW-1:0];
    assign SpWrData     = 32'd0;
    assign RegionBase   = r_region_base;
    assign RegionSize   = r_region_size;
    assign RegionValid  = r_region_valid;
    assign SpOverflow   = r_overflow;

endmodule

// File: tb/tb_spld_cmd_receiver.sv
// Directed bench for spld_cmd_receiver: expected SRAM writes are queued when a
// command is issued and popped as the DUT performs them.
module tb_spld_cmd_receiver;

    localparam int SP_DEPTH = 4096;
    localparam int SP_AW    = 12;
    localparam int SIZE_W   = 16;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              IFSPCmdValid;
    logic              IFSPCmdReady;
    logic [SIZE_W-1:0] MemSize;
    logic              isMemReplaceable;
    logic              SpWrEn;
    logic [SP_AW-1:0]  SpWrAddr;
    logic [31:0]       SpWrData;
    logic              SpWrReady;
    logic [SP_AW:0]    RegionBase;
    logic [SIZE_W-1:0] RegionSize;
    logic              RegionValid;
    logic              SpOverflow;

    typedef struct {
        int addr;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   m_free = 0;
    int   m_base = 0;
    int   m_size = 0;
    int   m_valid = 0;

    spld_cmd_receiver #(.SP_DEPTH(SP_DEPTH), .SP_AW(SP_AW), .SIZE_W(SIZE_W)) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .IFSPCmdValid     (IFSPCmdValid),
        .IFSPCmdReady     (IFSPCmdReady),
        .MemSize          (MemSize),
        .isMemReplaceable (isMemReplaceable),
        .SpWrEn           (SpWrEn),
        .SpWrAddr         (SpWrAddr),
        .SpWrData         (SpWrData),
        .SpWrReady        (SpWrReady),
        .RegionBase       (RegionBase),
        .RegionSize       (RegionSize),
        .RegionValid      (RegionValid),
        .SpOverflow       (SpOverflow)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_region();
        chk("region_base", 32'(RegionBase), m_base);
        chk("region_size", 32'(RegionSize), m_size);
        chk("region_valid", 32'(RegionValid), m_valid);
    endtask

    task automatic watch_write();
        exp_t e;
        if (SpWrEn === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_write", 32'(SpWrEn), 32'd0);
            end else begin
                e = q[0];
                chk("wr_addr", 32'(SpWrAddr), e.addr);
                chk("wr_data", SpWrData, 32'd0);
                if (SpWrReady === 1'b1) begin
                    chk("wr_cycle", cyc, e.cyc);
                    void'(q.pop_front());
                end
            end
        end
    endtask

    task automatic run_cmd(input int size, input bit repl, input int stall_at,
                           input int stall_len, input bit hold_valid);
        int base;
        int endp;
        int t;
        int k;
        int exp_rdy;
        bit ovf;
        exp_t e;
        @(negedge Clock);
        chk("idle_ready", 32'(IFSPCmdReady), 32'd1);
        chk("idle_wren", 32'(SpWrEn), 32'd0);
        base = repl ? 0 : m_free;
        endp = base + size;
        ovf  = (size != 0) && (endp > SP_DEPTH);
        IFSPCmdValid     = 1'b1;
        MemSize          = SIZE_W'(size);
        isMemReplaceable = repl;
        t = cyc;
        if (size == 0 || ovf) begin
            exp_rdy = t + 2;
            if (size == 0 && repl) begin
                m_free  = 0;
                m_valid = 0;
            end
        end else begin
            for (int j = 0; j < size; j++) begin
                e.addr = base + j;
                e.cyc  = t + 1 + j + ((j >= stall_at) ? stall_len : 0);
                q.push_back(e);
            end
            exp_rdy = t + size + stall_len + 2;
        end
        @(posedge Clock);
        #1;
        if (!hold_valid) IFSPCmdValid = 1'b0;
        k = 1;
        forever begin
            SpWrReady = !((k - 1) >= stall_at && (k - 1) < stall_at + stall_len);
            @(negedge Clock);
            if (k == 1) chk("overflow_pulse", 32'(SpOverflow), 32'(ovf));
            if (k == 2) chk("overflow_clear", 32'(SpOverflow), 32'd0);
            watch_write();
            if (IFSPCmdReady === 1'b1) break;
            if (k > size + stall_len + 8) begin
                chk("ready_timeout", 32'(IFSPCmdReady), 32'd1);
                break;
            end
            @(posedge Clock);
            #1;
            k++;
        end
        IFSPCmdValid = 1'b0;
        SpWrReady    = 1'b1;
        chk("ready_cycle", cyc, exp_rdy);
        chk("queue_empty", q.size(), 32'd0);
        if (size != 0 && !ovf) begin
            m_base  = base;
            m_size  = size;
            m_valid = 1;
            m_free  = endp;
        end
        check_region();
    endtask

    initial begin
        int t;
        exp_t e;
        Reset            = 1'b1;
        IFSPCmdValid     = 1'b0;
        MemSize          = '0;
        isMemReplaceable = 1'b0;
        SpWrReady        = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        chk("rst_ready", 32'(IFSPCmdReady), 32'd1);
        chk("rst_wren", 32'(SpWrEn), 32'd0);
        chk("rst_addr", 32'(SpWrAddr), 32'd0);
        chk("rst_overflow", 32'(SpOverflow), 32'd0);
        check_region();

        run_cmd(4, 1'b0, 9999, 0, 1'b0);
        run_cmd(3, 1'b0, 1, 2, 1'b0);
        run_cmd(4090, 1'b1, 99999, 0, 1'b0);
        run_cmd(7, 1'b0, 9999, 0, 1'b0);
        run_cmd(6, 1'b0, 9999, 0, 1'b0);
        run_cmd(1, 1'b0, 9999, 0, 1'b0);
        run_cmd(7, 1'b1, 9999, 0, 1'b0);
        run_cmd(0, 1'b0, 9999, 0, 1'b0);
        run_cmd(2, 1'b0, 9999, 0, 1'b1);

        // Reset after five writes of a ten-word fill
        @(negedge Clock);
        chk("pre_rst_ready", 32'(IFSPCmdReady), 32'd1);
        IFSPCmdValid     = 1'b1;
        MemSize          = SIZE_W'(10);
        isMemReplaceable = 1'b0;
        t = cyc;
        for (int j = 0; j < 5; j++) begin
            e.addr = m_free + j;
            e.cyc  = t + 1 + j;
            q.push_back(e);
        end
        @(posedge Clock);
        #1;
        IFSPCmdValid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clock);
            watch_write();
            @(posedge Clock);
            #1;
        end
        Reset = 1'b1;
        #1;
        chk("midfill_rst_wren", 32'(SpWrEn), 32'd0);
        chk("midfill_rst_ready", 32'(IFSPCmdReady), 32'd1);
        chk("midfill_rst_queue", q.size(), 32'd0);
        m_free  = 0;
        m_base  = 0;
        m_size  = 0;
        m_valid = 0;
        check_region();
        @(negedge Clock);
        Reset = 1'b0;

        run_cmd(3, 1'b0, 9999, 0, 1'b0);
        run_cmd(0, 1'b1, 9999, 0, 1'b0);
        run_cmd(1, 1'b0, 9999, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
